// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Pipeline sequencer for the 16-bit core. Tracks the destination registers of
// the instructions sitting in EX/MA/WB, raises load-use stalls, selects operand
// forwarding for the instruction in ID and kills ID issue for a few cycles
// after a taken branch/jump redirect resolved in EX.
//
// Parameters
//   FLUSH_CYCLES  cycles a redirect kills ID issue (1..7)
//   LOAD_STALL    stall cycles inserted on a load-use hit (1..3)
//
// Ports
//   i_clk           system clock, rising edge
//   i_rst_n         asynchronous active-low reset
//   i_id_valid      ID holds a real instruction
//   i_id_rs/rt      source registers of the ID instruction
//   i_id_rs_used    ID instruction reads rs
//   i_id_rt_used    ID instruction reads rt
//   i_id_wr         ID instruction writes the register file
//   i_id_waddr      ID destination register (4'hF for jal)
//   i_id_is_load    ID instruction is a load
//   i_ex_redirect   instruction in EX resolved a taken branch/jump this cycle
//   o_stall         hold PC and IF/ID
//   o_bubble        load a NOP into ID/EX this cycle
//   o_fwd_a/b       operand source: 00 regfile, 01 MA, 10 WB, 11 WB bypass
//   o_flushing      redirect flush window active
//   o_stall_count   saturating count of stall cycles since reset
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int LOAD_STALL   = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_id_valid,
    input  logic [3:0]  i_id_rs,
    input  logic [3:0]  i_id_rt,
    input  logic        i_id_rs_used,
    input  logic        i_id_rt_used,
    input  logic        i_id_wr,
    input  logic [3:0]  i_id_waddr,
    input  logic        i_id_is_load,
    input  logic        i_ex_redirect,
    output logic        o_stall,
    output logic        o_bubble,
    output logic [1:0]  o_fwd_a,
    output logic [1:0]  o_fwd_b,
    output logic        o_flushing,
    output logic [15:0] o_stall_count
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);
    localparam logic [1:0] STALL_LOAD = 2'(LOAD_STALL - 1);

    typedef struct packed {
        logic       valid;
        logic [3:0] waddr;
        logic       isLoad;
    } entry_t;

    typedef enum logic {
        ST_IDLE,
        ST_STALL
    } state_t;

    entry_t      r_ex;
    entry_t      r_ma;
    entry_t      r_wb;
    state_t      r_state;
    state_t      w_nextState;
    logic [1:0]  r_stallCnt;
    logic [1:0]  w_stallCntNext;
    logic [2:0]  r_flushCnt;
    logic [2:0]  w_flushCntNext;
    logic [15:0] r_stallCount;

    logic        w_hitExA;
    logic        w_hitExB;
    logic        w_loadUse;
    logic        w_stall;
    logic        w_flushing;
    logic        w_bubble;
    logic        w_issue;

    // A source hits an entry only when it is actually read and is not r0;
    // r0 writes are architecturally discarded so they must never forward.
    function automatic logic hit(input logic used, input logic [3:0] src,
                                 input entry_t e);
        return used && (src != 4'd0) && e.valid && (e.waddr == src);
    endfunction

    // Youngest producer wins: EX, then MA, then WB.
    function automatic logic [1:0] fwdSel(input logic used, input logic [3:0] src,
                                          input entry_t ex, input entry_t ma,
                                          input entry_t wb);
        if (hit(used, src, ex))      return 2'b01;
        else if (hit(used, src, ma)) return 2'b10;
        else if (hit(used, src, wb)) return 2'b11;
        else                         return 2'b00;
    endfunction

    assign w_hitExA  = hit(i_id_rs_used, i_id_rs, r_ex);
    assign w_hitExB  = hit(i_id_rt_used, i_id_rt, r_ex);
    assign w_loadUse = r_ex.isLoad && (w_hitExA || w_hitExB);

    // Stall sequencer. The detecting cycle is itself the first stall cycle;
    // STALL then covers the remaining LOAD_STALL-1 cycles. Once the counter
    // reaches zero the FSM evaluates like IDLE so forwarding picks the load
    // up from MA/WB. A redirect always wins: the stalled instruction is on the
    // wrong path anyway, so the stall is dropped and the flush takes over.
    always_comb begin
        w_nextState    = r_state;
        w_stallCntNext = r_stallCnt;
        w_stall        = 1'b0;
        if (i_ex_redirect) begin
            w_nextState    = ST_IDLE;
            w_stallCntNext = 2'd0;
        end else if ((r_state == ST_STALL) && (r_stallCnt != 2'd0)) begin
            w_stall        = 1'b1;
            w_stallCntNext = r_stallCnt - 2'd1;
        end else if (w_loadUse) begin
            w_stall        = 1'b1;
            w_nextState    = ST_STALL;
            w_stallCntNext = STALL_LOAD;
        end else begin
            w_nextState    = ST_IDLE;
        end
    end

    // Flush window: a redirect (re)loads the counter, which then drains by one
    // per cycle. PC is not held while flushing so the target gets fetched.
    always_comb begin
        w_flushCntNext = 3'd0;
        if (i_ex_redirect) begin
            w_flushCntNext = FLUSH_LOAD;
        end else if (r_flushCnt != 3'd0) begin
            w_flushCntNext = r_flushCnt - 3'd1;
        end
    end

    assign w_flushing = (r_flushCnt != 3'd0);
    // Any cycle that inserts a NOP into ID/EX also keeps the ID instruction
    // out of the tracking pipe; r0 destinations are never tracked.
    assign w_bubble   = w_stall || w_flushing || i_ex_redirect;
    assign w_issue    = i_id_valid && i_id_wr && !w_bubble && (i_id_waddr != 4'd0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_stallCnt <= 2'd0;
            r_flushCnt <= 3'd0;
        end else begin
            r_state    <= w_nextState;
            r_stallCnt <= w_stallCntNext;
            r_flushCnt <= w_flushCntNext;
        end
    end

    // Destination tracking pipe mirroring EX -> MA -> WB.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ex <= '0;
            r_ma <= '0;
            r_wb <= '0;
        end else begin
            r_wb <= r_ma;
            r_ma <= r_ex;
            r_ex <= w_issue ? entry_t'{1'b1, i_id_waddr, i_id_is_load} : entry_t'('0);
        end
    end

    // Stall cycle counter, saturating rather than wrapping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stallCount <= 16'd0;
        end else if (w_stall && (r_stallCount != 16'hFFFF)) begin
            r_stallCount <= r_stallCount + 16'd1;
        end
    end

    assign o_stall       = w_stall;
    assign o_bubble      = w_bubble;
    assign o_fwd_a       = fwdSel(i_id_rs_used, i_id_rs, r_ex, r_ma, r_wb);
    assign o_fwd_b       = fwdSel(i_id_rt_used, i_id_rt, r_ex, r_ma, r_wb);
    assign o_flushing    = w_flushing;
    assign o_stall_count = r_stallCount;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
// Bench for hazard_ctrl: a directed vector table walking the classic hazard
// cases, hand sequences for reset/flush corner cases, a randomized phase
// against a behavioural pipeline model, and a long load-use loop that drives
// the stall counter into saturation.
module tb_hazard_ctrl;

    localparam int FLUSH_CYCLES = 2;
    localparam int LOAD_STALL   = 3;

    logic        clk;
    logic        rstN;
    logic        idValid;
    logic [3:0]  idRs;
    logic [3:0]  idRt;
    logic        idRsUsed;
    logic        idRtUsed;
    logic        idWr;
    logic [3:0]  idWaddr;
    logic        idIsLoad;
    logic        exRedirect;
    logic        stall;
    logic        bubble;
    logic [1:0]  fwdA;
    logic [1:0]  fwdB;
    logic        flushing;
    logic [15:0] stallCount;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(
        .FLUSH_CYCLES(FLUSH_CYCLES),
        .LOAD_STALL  (LOAD_STALL)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_id_valid   (idValid),
        .i_id_rs      (idRs),
        .i_id_rt      (idRt),
        .i_id_rs_used (idRsUsed),
        .i_id_rt_used (idRtUsed),
        .i_id_wr      (idWr),
        .i_id_waddr   (idWaddr),
        .i_id_is_load (idIsLoad),
        .i_ex_redirect(exRedirect),
        .o_stall      (stall),
        .o_bubble     (bubble),
        .o_fwd_a      (fwdA),
        .o_fwd_b      (fwdB),
        .o_flushing   (flushing),
        .o_stall_count(stallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [3:0] rs;
        logic [3:0] rt;
        logic       rsUsed;
        logic       rtUsed;
        logic       wr;
        logic [3:0] waddr;
        logic       isLoad;
        logic       redirect;
        logic       expStall;
        logic       expBubble;
        logic [1:0] expFwdA;
        logic [1:0] expFwdB;
        logic       expFlushing;
    } vec_t;

    vec_t vecs[24];

    // Behavioural model: the last three issued writers, newest first, plus
    // plain counts of remaining stall and flush cycles.
    typedef struct {
        logic       valid;
        logic [3:0] waddr;
        logic       isLoad;
    } ment_t;

    ment_t mHist[3];
    int    mStallLeft;
    int    mFlushLeft;
    int    mStallTotal;
    logic  mStall;
    logic  mBubble;
    logic  mFlushing;

    function automatic vec_t mkVec(logic v, logic [3:0] rs, logic [3:0] rt,
                                   logic rsU, logic rtU, logic wr, logic [3:0] wa,
                                   logic ld, logic red, logic eSt, logic eBu,
                                   logic [1:0] eFa, logic [1:0] eFb, logic eFl);
        vec_t r;
        r.valid = v;   r.rs = rs;       r.rt = rt;       r.rsUsed = rsU;
        r.rtUsed = rtU; r.wr = wr;      r.waddr = wa;    r.isLoad = ld;
        r.redirect = red; r.expStall = eSt; r.expBubble = eBu;
        r.expFwdA = eFa; r.expFwdB = eFb; r.expFlushing = eFl;
        return r;
    endfunction

    task automatic applyStimulus(input vec_t v);
        idValid    = v.valid;
        idRs       = v.rs;
        idRt       = v.rt;
        idRsUsed   = v.rsUsed;
        idRtUsed   = v.rtUsed;
        idWr       = v.wr;
        idWaddr    = v.waddr;
        idIsLoad   = v.isLoad;
        exRedirect = v.redirect;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] modelFwd(logic used, logic [3:0] src);
        for (int i = 0; i < 3; i++) begin
            if (used && src != 4'd0 && mHist[i].valid && mHist[i].waddr == src)
                return 2'(i + 1);
        end
        return 2'b00;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 3; i++) mHist[i] = '{1'b0, 4'd0, 1'b0};
        mStallLeft  = 0;
        mFlushLeft  = 0;
        mStallTotal = 0;
    endtask

    task automatic modelEval();
        mStall = 1'b0;
        if (!exRedirect) begin
            if (mStallLeft > 0)
                mStall = 1'b1;
            else if (mHist[0].isLoad &&
                     (modelFwd(idRsUsed, idRs) == 2'b01 || modelFwd(idRtUsed, idRt) == 2'b01))
                mStall = 1'b1;
        end
        mFlushing = (mFlushLeft > 0);
        mBubble   = mStall || mFlushing || exRedirect;
    endtask

    task automatic modelAdvance();
        if (exRedirect)          mStallLeft = 0;
        else if (mStallLeft > 0) mStallLeft--;
        else if (mStall)         mStallLeft = LOAD_STALL - 1;
        if (exRedirect)          mFlushLeft = FLUSH_CYCLES;
        else if (mFlushLeft > 0) mFlushLeft--;
        mHist[2] = mHist[1];
        mHist[1] = mHist[0];
        mHist[0] = '{idValid && idWr && !mBubble, idWaddr, idIsLoad};
        if (mStall && mStallTotal < 65535) mStallTotal++;
    endtask

    task automatic resetDut();
        rstN = 1'b0;
        #2;
        rstN = 1'b1;
        modelReset();
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, ".stall"},    16'(stall),    16'(mStall));
        checkOutput({tag, ".bubble"},   16'(bubble),   16'(mBubble));
        checkOutput({tag, ".fwdA"},     16'(fwdA),     16'(modelFwd(idRsUsed, idRs)));
        checkOutput({tag, ".fwdB"},     16'(fwdB),     16'(modelFwd(idRtUsed, idRt)));
        checkOutput({tag, ".flushing"}, 16'(flushing), 16'(mFlushing));
        checkOutput({tag, ".count"},    stallCount,    16'(mStallTotal));
    endtask

    initial begin
        vec_t nullVec;
        vec_t cur;
        nullVec = mkVec(0,0,0,0,0,0,0,0,0, 0,0,0,0,0);

        // Directed hazard walk; parameters are FLUSH_CYCLES=2, LOAD_STALL=3.
        //                v rs rt rU tU wr wa ld rd  st bu fa fb fl
        vecs[0]  = mkVec(1, 2, 3, 1, 1, 1, 1, 0, 0,  0, 0, 0, 0, 0);
        vecs[1]  = mkVec(1, 1, 5, 1, 1, 1, 4, 0, 0,  0, 0, 1, 0, 0);
        vecs[2]  = mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        vecs[3]  = mkVec(1, 1, 4, 1, 1, 0, 0, 0, 0,  0, 0, 3, 2, 0);
        vecs[4]  = mkVec(1, 3, 0, 1, 0, 1, 2, 1, 0,  0, 0, 0, 0, 0);
        vecs[5]  = mkVec(1, 2, 2, 1, 1, 1, 3, 0, 0,  1, 1, 1, 1, 0);
        vecs[6]  = mkVec(1, 2, 2, 1, 1, 1, 3, 0, 0,  1, 1, 2, 2, 0);
        vecs[7]  = mkVec(1, 2, 2, 1, 1, 1, 3, 0, 0,  1, 1, 3, 3, 0);
        vecs[8]  = mkVec(1, 2, 2, 1, 1, 1, 3, 0, 0,  0, 0, 0, 0, 0);
        vecs[9]  = mkVec(1, 0, 0, 0, 0, 1, 5, 0, 1,  0, 1, 0, 0, 0);
        vecs[10] = mkVec(1, 3, 0, 1, 0, 1, 6, 0, 0,  0, 1, 2, 0, 1);
        vecs[11] = mkVec(1, 3, 0, 1, 0, 1, 6, 0, 0,  0, 1, 3, 0, 1);
        vecs[12] = mkVec(1, 3, 0, 1, 0, 1, 6, 0, 0,  0, 0, 0, 0, 0);
        vecs[13] = mkVec(1, 6, 0, 1, 0, 1, 2, 1, 0,  0, 0, 1, 0, 0);
        vecs[14] = mkVec(1, 2, 0, 1, 0, 1, 3, 0, 0,  1, 1, 1, 0, 0);
        vecs[15] = mkVec(1, 2, 0, 1, 0, 1, 3, 0, 1,  0, 1, 2, 0, 0);
        vecs[16] = mkVec(1, 2, 0, 1, 0, 1, 3, 0, 0,  0, 1, 3, 0, 1);
        vecs[17] = mkVec(1, 2, 0, 1, 0, 1, 3, 0, 0,  0, 1, 0, 0, 1);
        vecs[18] = mkVec(1, 2, 0, 1, 0, 1, 3, 0, 0,  0, 0, 0, 0, 0);
        vecs[19] = mkVec(1, 0, 0, 1, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0);
        vecs[20] = mkVec(1, 0, 0, 1, 1, 1, 0, 1, 0,  0, 0, 0, 0, 0);
        vecs[21] = mkVec(1, 0, 0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        vecs[22] = mkVec(1, 0, 0, 0, 0, 1, 15, 0, 0, 0, 0, 0, 0, 0);
        vecs[23] = mkVec(1, 15, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        rstN = 1'b0;
        applyStimulus(nullVec);
        #12;
        checkOutput("reset.stall",    16'(stall),    16'd0);
        checkOutput("reset.bubble",   16'(bubble),   16'd0);
        checkOutput("reset.fwdA",     16'(fwdA),     16'd0);
        checkOutput("reset.fwdB",     16'(fwdB),     16'd0);
        checkOutput("reset.flushing", 16'(flushing), 16'd0);
        checkOutput("reset.count",    stallCount,    16'd0);
        rstN = 1'b1;
        stepClock();

        for (int i = 0; i < 24; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("vec%0d.stall", i),    16'(stall),    16'(vecs[i].expStall));
            checkOutput($sformatf("vec%0d.bubble", i),   16'(bubble),   16'(vecs[i].expBubble));
            checkOutput($sformatf("vec%0d.fwdA", i),     16'(fwdA),     16'(vecs[i].expFwdA));
            checkOutput($sformatf("vec%0d.fwdB", i),     16'(fwdB),     16'(vecs[i].expFwdB));
            checkOutput($sformatf("vec%0d.flushing", i), 16'(flushing), 16'(vecs[i].expFlushing));
            stepClock();
        end
        checkOutput("table.count", stallCount, 16'd4);

        // Redirect during an active flush restarts the full window.
        cur = nullVec; cur.redirect = 1'b1;
        applyStimulus(cur);
        @(negedge clk);
        checkOutput("reload.c0.bubble",   16'(bubble),   16'd1);
        checkOutput("reload.c0.flushing", 16'(flushing), 16'd0);
        stepClock();
        @(negedge clk);
        checkOutput("reload.c1.flushing", 16'(flushing), 16'd1);
        stepClock();
        applyStimulus(nullVec);
        @(negedge clk);
        checkOutput("reload.c2.flushing", 16'(flushing), 16'd1);
        checkOutput("reload.c2.stall",    16'(stall),    16'd0);
        stepClock();
        @(negedge clk);
        checkOutput("reload.c3.flushing", 16'(flushing), 16'd1);
        stepClock();
        @(negedge clk);
        checkOutput("reload.c4.flushing", 16'(flushing), 16'd0);
        checkOutput("reload.c4.bubble",   16'(bubble),   16'd0);
        stepClock();

        // Reset in the middle of a load-use stall.
        applyStimulus(mkVec(1, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0));
        stepClock();
        applyStimulus(mkVec(1, 2, 0, 1, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        checkOutput("midStall.stall", 16'(stall), 16'd1);
        #1 rstN = 1'b0;
        #1;
        checkOutput("midStall.rst.stall",    16'(stall),    16'd0);
        checkOutput("midStall.rst.bubble",   16'(bubble),   16'd0);
        checkOutput("midStall.rst.fwdA",     16'(fwdA),     16'd0);
        checkOutput("midStall.rst.count",    stallCount,    16'd0);
        rstN = 1'b1;
        stepClock();
        @(negedge clk);
        checkOutput("midStall.after.stall", 16'(stall),  16'd0);
        checkOutput("midStall.after.count", stallCount,  16'd0);
        stepClock();

        // Reset in the middle of a flush window.
        cur = nullVec; cur.redirect = 1'b1;
        applyStimulus(cur);
        stepClock();
        applyStimulus(nullVec);
        @(negedge clk);
        checkOutput("midFlush.flushing", 16'(flushing), 16'd1);
        #1 rstN = 1'b0;
        #1;
        checkOutput("midFlush.rst.flushing", 16'(flushing), 16'd0);
        checkOutput("midFlush.rst.bubble",   16'(bubble),   16'd0);
        rstN = 1'b1;
        stepClock();
        @(negedge clk);
        checkOutput("midFlush.after.flushing", 16'(flushing), 16'd0);
        checkOutput("midFlush.after.bubble",   16'(bubble),   16'd0);
        stepClock();

        // Randomized traffic against the behavioural model.
        resetDut();
        stepClock();
        for (int n = 0; n < 2000; n++) begin
            cur.valid    = 1'($urandom_range(0, 7) != 0);
            cur.rs       = 4'($urandom_range(0, 3));
            cur.rt       = 4'($urandom_range(0, 3));
            cur.rsUsed   = 1'($urandom_range(0, 1));
            cur.rtUsed   = 1'($urandom_range(0, 1));
            cur.wr       = 1'($urandom_range(0, 3) != 0);
            cur.waddr    = 4'($urandom_range(0, 3));
            cur.isLoad   = 1'($urandom_range(0, 2) == 0);
            cur.redirect = 1'($urandom_range(0, 7) == 0);
            applyStimulus(cur);
            modelEval();
            @(negedge clk);
            checkModel($sformatf("rand%0d", n));
            @(posedge clk);
            modelAdvance();
            #1;
        end

        // Back-to-back dependent loads keep the stall FSM busy long enough
        // to push the stall counter past its 16-bit limit.
        resetDut();
        stepClock();
        applyStimulus(mkVec(1, 2, 0, 1, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0));
        for (int n = 0; n < 87500; n++) begin
            modelEval();
            if ((n % 4096) == 4095) begin
                @(negedge clk);
                checkOutput($sformatf("sat%0d.count", n), stallCount, 16'(mStallTotal));
            end
            @(posedge clk);
            modelAdvance();
        end
        #1;
        @(negedge clk);
        checkOutput("sat.final.count", stallCount, 16'hFFFF);
        checkOutput("sat.final.model", stallCount, 16'(mStallTotal));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
